// File: rtl/uc_tile_host.sv
// Host-side driver for the 8-bit uC tile: flash image, 256x8 data SRAM emulation, stepped tile clock.
// Optional `BREAKPOINT_EN adds a PC breakpoint that halts free-run stepping.
module uc_tile_host #(
   parameter int REG_WIDTH     = 32,
   parameter int CSR_IN_WIDTH  = 16,
   parameter int CSR_OUT_WIDTH = 16,
   parameter int FLASH_AW      = 8,
   parameter int HALF_PERIOD   = 2
) (
   input  logic                     clk,
   input  logic                     arst,
   output logic [CSR_IN_WIDTH-1:0]  tile_csr_in,
   output logic [REG_WIDTH-1:0]     tile_reg_a,
   output logic [REG_WIDTH-1:0]     tile_reg_b,
   input  logic [REG_WIDTH-1:0]     tile_reg_c,
   input  logic [CSR_OUT_WIDTH-1:0] tile_csr_out,
   input  logic                     prog_we,
   input  logic [FLASH_AW-1:0]      prog_addr,
   input  logic [15:0]              prog_data,
   input  logic                     prog_done,
   input  logic                     run,
   input  logic                     step_req,
`ifdef BREAKPOINT_EN
   input  logic                     bp_en,
   input  logic [11:0]              bp_addr,
   output logic                     bp_hit,
`endif
   output logic                     busy,
   output logic                     step_done,
   output logic [15:0]              step_count,
   output logic                     pc_oob
);

   localparam int CW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
   localparam logic [CW-1:0] PH_LAST = CW'(HALF_PERIOD - 1);

   typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH} state_t;

   typedef struct packed {
      logic [11:0] pc;
      logic [7:0]  wdata;
      logic [7:0]  addr;
      logic        we;
   } tile_req_t;

   state_t         state;
   logic [CW-1:0]  ph_cnt;
   logic           tclk;
   logic           flash_ready;
   logic [7:0]     reg_a_q;
   logic [15:0]    reg_b_q;
   logic           bp_stop;

   logic [15:0]    flash [0:(1<<FLASH_AW)-1];
   logic [7:0]     sram  [0:255];

   tile_req_t      req;
   logic           pc_in_oob;
   logic [15:0]    flash_rd;
   logic           bp_match;
   logic           unused_bits;

   assign req.pc    = tile_reg_c[27:16];
   assign req.wdata = tile_reg_c[15:8];
   assign req.addr  = tile_reg_c[7:0];
   assign req.we    = tile_csr_out[2];

   assign pc_in_oob = |(32'(req.pc) >> FLASH_AW);
   assign flash_rd  = pc_in_oob ? 16'h0000 : flash[req.pc[FLASH_AW-1:0]];

`ifdef BREAKPOINT_EN
   assign bp_match = bp_en && (req.pc == bp_addr);
`else
   assign bp_match = 1'b0;
`endif

   // Bootstrapping flag and upper reg_c bits carry nothing the host acts on.
   assign unused_bits = ^{tile_reg_c[REG_WIDTH-1:28], tile_csr_out[CSR_OUT_WIDTH-1:3],
                          tile_csr_out[1:0]};

   always_comb begin
      tile_csr_in    = '0;
      tile_csr_in[5] = tclk;
      tile_csr_in[4] = flash_ready;
   end

   assign tile_reg_a = REG_WIDTH'(reg_a_q);
   assign tile_reg_b = REG_WIDTH'(reg_b_q);

   always_ff @(posedge clk) begin
      if (prog_we)
         flash[prog_addr] <= prog_data;
   end

   // SRAM write commits on the LOW->HIGH edge, so a read on the following step sees it.
   always_ff @(posedge clk) begin
      if (state == S_LOW && ph_cnt == PH_LAST && req.we)
         sram[req.addr] <= req.wdata;
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state       <= S_IDLE;
         ph_cnt      <= '0;
         tclk        <= 1'b0;
         flash_ready <= 1'b0;
         reg_a_q     <= '0;
         reg_b_q     <= '0;
         busy        <= 1'b0;
         step_done   <= 1'b0;
         step_count  <= '0;
         pc_oob      <= 1'b0;
         bp_stop     <= 1'b0;
`ifdef BREAKPOINT_EN
         bp_hit      <= 1'b0;
`endif
      end else begin
         step_done <= 1'b0;
         if (prog_done)
            flash_ready <= 1'b1;

         case (state)
            S_IDLE: begin
               if (run || step_req) begin
                  state   <= S_LOW;
                  ph_cnt  <= '0;
                  tclk    <= 1'b0;
                  busy    <= 1'b1;
                  bp_stop <= 1'b0;
`ifdef BREAKPOINT_EN
                  bp_hit  <= 1'b0;
`endif
               end
            end

            S_LOW: begin
               if (ph_cnt == '0) begin
                  reg_b_q <= flash_rd;
                  reg_a_q <= sram[req.addr];
                  bp_stop <= bp_match;
                  if (pc_in_oob)
                     pc_oob <= 1'b1;
               end
               if (ph_cnt == PH_LAST) begin
                  state  <= S_HIGH;
                  ph_cnt <= '0;
                  tclk   <= 1'b1;
               end else begin
                  ph_cnt <= ph_cnt + 1'b1;
               end
            end

            S_HIGH: begin
               if (ph_cnt == PH_LAST) begin
                  step_done  <= 1'b1;
                  step_count <= step_count + 16'd1;
                  ph_cnt     <= '0;
`ifdef BREAKPOINT_EN
                  bp_hit     <= bp_stop;
`endif
                  // Free-run goes straight into the next LOW; otherwise park with the tile clock high.
                  if (run && !bp_stop) begin
                     state <= S_LOW;
                     tclk  <= 1'b0;
                  end else begin
                     state <= S_IDLE;
                     busy  <= 1'b0;
                  end
               end else begin
                  ph_cnt <= ph_cnt + 1'b1;
               end
            end

            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uc_tile_host.sv
// Directed self-checking bench for uc_tile_host (default parameters, HALF_PERIOD=2, FLASH_AW=8).
module tb_uc_tile_host;

   localparam int REG_WIDTH     = 32;
   localparam int CSR_IN_WIDTH  = 16;
   localparam int CSR_OUT_WIDTH = 16;
   localparam int FLASH_AW      = 8;
   localparam int HALF_PERIOD   = 2;

   logic                     clk = 1'b0;
   logic                     arst;
   logic [CSR_IN_WIDTH-1:0]  tile_csr_in;
   logic [REG_WIDTH-1:0]     tile_reg_a;
   logic [REG_WIDTH-1:0]     tile_reg_b;
   logic [REG_WIDTH-1:0]     tile_reg_c;
   logic [CSR_OUT_WIDTH-1:0] tile_csr_out;
   logic                     prog_we;
   logic [FLASH_AW-1:0]      prog_addr;
   logic [15:0]              prog_data;
   logic                     prog_done;
   logic                     run;
   logic                     step_req;
   logic                     busy;
   logic                     step_done;
   logic [15:0]              step_count;
   logic                     pc_oob;
`ifdef BREAKPOINT_EN
   logic                     bp_en;
   logic [11:0]              bp_addr;
   logic                     bp_hit;
`endif

   int errors = 0;
   int checks = 0;
   int exp_steps = 0;

   uc_tile_host #(
      .REG_WIDTH(REG_WIDTH), .CSR_IN_WIDTH(CSR_IN_WIDTH), .CSR_OUT_WIDTH(CSR_OUT_WIDTH),
      .FLASH_AW(FLASH_AW), .HALF_PERIOD(HALF_PERIOD)
   ) dut (
      .clk(clk), .arst(arst), .tile_csr_in(tile_csr_in), .tile_reg_a(tile_reg_a),
      .tile_reg_b(tile_reg_b), .tile_reg_c(tile_reg_c), .tile_csr_out(tile_csr_out),
      .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data), .prog_done(prog_done),
      .run(run), .step_req(step_req),
`ifdef BREAKPOINT_EN
      .bp_en(bp_en), .bp_addr(bp_addr), .bp_hit(bp_hit),
`endif
      .busy(busy), .step_done(step_done), .step_count(step_count), .pc_oob(pc_oob)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic set_c(input logic [11:0] pc, input logic [7:0] wd, input logic [7:0] ad);
      tile_reg_c = {4'h0, pc, wd, ad};
   endtask

   task automatic prog_word(input logic [FLASH_AW-1:0] a, input logic [15:0] d);
      prog_we = 1'b1; prog_addr = a; prog_data = d;
      @(posedge clk); #1;
      prog_we = 1'b0;
   endtask

   // One step via step_req; waits for step_done (bounded) and returns at posedge+1 in IDLE.
   task automatic do_step();
      int n = 0;
      step_req = 1'b1;
      @(posedge clk); #1;
      step_req = 1'b0;
      do begin
         @(negedge clk); n++;
      end while (!step_done && n < 40);
      checks++;
      if (!step_done) begin
         errors++;
         $display("FAIL step_timeout: step_done=%0b after %0d cycles, expected 1", step_done, n);
      end
      exp_steps++;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      arst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++; if (tile_csr_in !== 16'h0000) begin errors++; $display("FAIL rst_csr_in: got %h want 0000", tile_csr_in); end
      checks++; if (tile_reg_a !== 32'h0) begin errors++; $display("FAIL rst_reg_a: got %h want 0", tile_reg_a); end
      checks++; if (tile_reg_b !== 32'h0) begin errors++; $display("FAIL rst_reg_b: got %h want 0", tile_reg_b); end
      checks++; if (busy !== 1'b0 || step_done !== 1'b0) begin errors++; $display("FAIL rst_busy_done: got %b%b want 00", busy, step_done); end
      checks++; if (step_count !== 16'h0) begin errors++; $display("FAIL rst_count: got %h want 0", step_count); end
      checks++; if (pc_oob !== 1'b0) begin errors++; $display("FAIL rst_pc_oob: got %b want 0", pc_oob); end
      @(posedge clk); #1;
      arst = 1'b0;
   endtask

   task automatic test_flash_load_and_timing();
      prog_word(8'h00, 16'h1111);
      prog_word(8'h01, 16'h2222);
      prog_word(8'h02, 16'h3333);
      prog_word(8'h03, 16'h4444);
      checks++; if (tile_csr_in[4] !== 1'b0) begin errors++; $display("FAIL ready_before_done: got %b want 0", tile_csr_in[4]); end
      prog_done = 1'b1;
      @(posedge clk); #1;
      prog_done = 1'b0;
      checks++; if (tile_csr_in[4] !== 1'b1) begin errors++; $display("FAIL flash_ready: got %b want 1", tile_csr_in[4]); end
      set_c(12'h000, 8'h00, 8'h00);
      tile_csr_out = '0;
      step_req = 1'b1;
      @(posedge clk); #1;
      step_req = 1'b0;
      @(negedge clk);
      checks++; if (tile_csr_in[5] !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL low1: tclk=%b busy=%b want 0 1", tile_csr_in[5], busy); end
      @(negedge clk);
      checks++; if (tile_csr_in[5] !== 1'b0) begin errors++; $display("FAIL low2_tclk: got %b want 0", tile_csr_in[5]); end
      checks++; if (tile_reg_b !== 32'h0000_1111) begin errors++; $display("FAIL fetch_pc0: got %h want 00001111", tile_reg_b); end
      @(negedge clk);
      checks++; if (tile_csr_in[5] !== 1'b1) begin errors++; $display("FAIL high1_tclk: got %b want 1", tile_csr_in[5]); end
      @(negedge clk);
      checks++; if (tile_csr_in[5] !== 1'b1 || step_done !== 1'b0) begin errors++; $display("FAIL high2: tclk=%b done=%b want 1 0", tile_csr_in[5], step_done); end
      @(negedge clk);
      checks++; if (step_done !== 1'b1 || busy !== 1'b0 || tile_csr_in[5] !== 1'b1) begin errors++; $display("FAIL step_end: done=%b busy=%b tclk=%b want 1 0 1", step_done, busy, tile_csr_in[5]); end
      checks++; if (step_count !== 16'd1) begin errors++; $display("FAIL count1: got %0d want 1", step_count); end
      @(negedge clk);
      checks++; if (step_done !== 1'b0) begin errors++; $display("FAIL done_pulse: got %b want 0", step_done); end
      exp_steps = 1;
      @(posedge clk); #1;
   endtask

   task automatic test_sram();
      set_c(12'h001, 8'hA5, 8'h3C); tile_csr_out = 16'h0004;
      do_step();
      set_c(12'h001, 8'h00, 8'h3C); tile_csr_out = 16'h0000;
      do_step();
      checks++; if (tile_reg_a !== 32'h0000_00A5) begin errors++; $display("FAIL sram_rd_3c: got %h want 000000a5", tile_reg_a); end
      checks++; if (tile_reg_b !== 32'h0000_2222) begin errors++; $display("FAIL fetch_pc1: got %h want 00002222", tile_reg_b); end
      set_c(12'h002, 8'h5A, 8'h3D); tile_csr_out = 16'h0004;
      do_step();
      checks++; if (tile_reg_b !== 32'h0000_3333) begin errors++; $display("FAIL fetch_pc2: got %h want 00003333", tile_reg_b); end
      set_c(12'h003, 8'hFF, 8'h3D); tile_csr_out = 16'h0000;
      do_step();
      checks++; if (tile_reg_a !== 32'h0000_005A) begin errors++; $display("FAIL sram_rd_3d: got %h want 0000005a", tile_reg_a); end
      checks++; if (tile_reg_b !== 32'h0000_4444) begin errors++; $display("FAIL fetch_pc3: got %h want 00004444", tile_reg_b); end
      set_c(12'h000, 8'hFF, 8'h3C);
      do_step();
      set_c(12'h000, 8'h00, 8'h3C);
      do_step();
      checks++; if (tile_reg_a !== 32'h0000_00A5) begin errors++; $display("FAIL sram_no_we: got %h want 000000a5", tile_reg_a); end
      checks++; if (step_count !== 16'(exp_steps)) begin errors++; $display("FAIL count_sram: got %0d want %0d", step_count, exp_steps); end
   endtask

   task automatic test_flash_update();
      prog_word(8'h00, 16'hBEEF);
      prog_word(8'hFF, 16'h7777);
      set_c(12'h000, 8'h00, 8'h3C);
      do_step();
      checks++; if (tile_reg_b !== 32'h0000_BEEF) begin errors++; $display("FAIL fetch_rewrite: got %h want 0000beef", tile_reg_b); end
      set_c(12'h0FF, 8'h00, 8'h3C);
      do_step();
      checks++; if (tile_reg_b !== 32'h0000_7777) begin errors++; $display("FAIL fetch_top: got %h want 00007777", tile_reg_b); end
      checks++; if (pc_oob !== 1'b0) begin errors++; $display("FAIL oob_top: got %b want 0", pc_oob); end
   endtask

   task automatic test_pc_oob();
      set_c(12'h100, 8'h00, 8'h3C);
      do_step();
      checks++; if (tile_reg_b !== 32'h0) begin errors++; $display("FAIL oob_data: got %h want 0", tile_reg_b); end
      checks++; if (pc_oob !== 1'b1) begin errors++; $display("FAIL oob_set: got %b want 1", pc_oob); end
      set_c(12'h001, 8'h00, 8'h3C);
      do_step();
      checks++; if (pc_oob !== 1'b1 || tile_reg_b !== 32'h0000_2222) begin errors++; $display("FAIL oob_sticky: oob=%b reg_b=%h want 1 00002222", pc_oob, tile_reg_b); end
   endtask

   task automatic test_back_to_back();
      int n = 0;
      step_req = 1'b1;
      @(posedge clk); #1;
      step_req = 1'b0;
      @(posedge clk); #1;
      step_req = 1'b1;
      @(posedge clk); #1;
      step_req = 1'b0;
      while (busy && n < 40) begin @(negedge clk); n++; end
      repeat (8) @(negedge clk);
      exp_steps++;
      checks++; if (step_count !== 16'(exp_steps) || busy !== 1'b0) begin errors++; $display("FAIL req_while_busy: count=%0d busy=%b want %0d 0", step_count, busy, exp_steps); end
      @(posedge clk); #1;
   endtask

   task automatic test_run();
      int n = 0;
      int cyc = 0;
      logic first_busy = 1'b0;
      set_c(12'h001, 8'h00, 8'h3C);
      run = 1'b1;
      while (n < 10 && cyc < 400) begin
         @(negedge clk); cyc++;
         if (step_done) begin
            n++;
            if (n == 1) first_busy = busy;
         end
         if (n == 9 && tile_csr_in[5] && run) run = 1'b0;
      end
      exp_steps += 10;
      checks++; if (n != 10) begin errors++; $display("FAIL run_timeout: saw %0d step_done, want 10", n); end
      checks++; if (first_busy !== 1'b1) begin errors++; $display("FAIL run_no_bubble: busy=%b at step_done, want 1", first_busy); end
      checks++; if (step_count !== 16'(exp_steps)) begin errors++; $display("FAIL run_count: got %0d want %0d", step_count, exp_steps); end
      checks++; if (busy !== 1'b0 || tile_csr_in[5] !== 1'b1) begin errors++; $display("FAIL run_stop: busy=%b tclk=%b want 0 1", busy, tile_csr_in[5]); end
      repeat (6) @(negedge clk);
      checks++; if (step_count !== 16'(exp_steps) || busy !== 1'b0) begin errors++; $display("FAIL run_idle: count=%0d busy=%b want %0d 0", step_count, busy, exp_steps); end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid_low();
      set_c(12'h001, 8'h00, 8'h3C);
      step_req = 1'b1;
      @(posedge clk); #1;
      step_req = 1'b0;
      @(negedge clk);
      arst = 1'b1;
      #1;
      checks++; if (tile_csr_in !== 16'h0000) begin errors++; $display("FAIL arst_csr_in: got %h want 0000", tile_csr_in); end
      checks++; if (busy !== 1'b0 || step_count !== 16'h0) begin errors++; $display("FAIL arst_state: busy=%b count=%0d want 0 0", busy, step_count); end
      checks++; if (pc_oob !== 1'b0 || tile_reg_b !== 32'h0) begin errors++; $display("FAIL arst_oob_regb: oob=%b reg_b=%h want 0 0", pc_oob, tile_reg_b); end
      @(posedge clk); #1;
      arst = 1'b0;
      exp_steps = 0;
      do_step();
      checks++; if (tile_reg_b !== 32'h0000_2222 || step_count !== 16'd1) begin errors++; $display("FAIL post_arst: reg_b=%h count=%0d want 00002222 1", tile_reg_b, step_count); end
      checks++; if (tile_csr_in[4] !== 1'b0) begin errors++; $display("FAIL post_arst_ready: got %b want 0", tile_csr_in[4]); end
   endtask

`ifdef BREAKPOINT_EN
   task automatic test_breakpoint();
      int n = 0;
      int cyc = 0;
      logic [11:0] pc = 12'h000;
      set_c(pc, 8'h00, 8'h3C);
      bp_addr = 12'h002; bp_en = 1'b1; run = 1'b1;
      while (cyc < 200 && !(n > 0 && !busy)) begin
         @(negedge clk); cyc++;
         if (step_done) begin n++; pc = pc + 12'h001; set_c(pc, 8'h00, 8'h3C); end
      end
      checks++; if (n != 3 || bp_hit !== 1'b1) begin errors++; $display("FAIL bp_stop: steps=%0d bp_hit=%b want 3 1", n, bp_hit); end
      run = 1'b0;
      do_step();
      checks++; if (bp_hit !== 1'b0) begin errors++; $display("FAIL bp_clear: got %b want 0", bp_hit); end
      bp_en = 1'b0;
   endtask
`endif

   initial begin
      arst = 1'b1; tile_reg_c = '0; tile_csr_out = '0;
      prog_we = 1'b0; prog_addr = '0; prog_data = '0; prog_done = 1'b0;
      run = 1'b0; step_req = 1'b0;
`ifdef BREAKPOINT_EN
      bp_en = 1'b0; bp_addr = '0;
`endif
      test_reset();
      test_flash_load_and_timing();
      test_sram();
      test_flash_update();
      test_pc_oob();
      test_back_to_back();
      test_run();
      test_reset_mid_low();
`ifdef BREAKPOINT_EN
      test_breakpoint();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
